// File: rtl/pe_mac_acc_if.sv
// Operand/result bus of the systolic MAC processing element: input beat, neighbour pass-through and result handshake.
interface pe_mac_acc_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 1,
    parameter int ACC_WIDTH  = 32
);
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_last;
    logic [LANES*DATA_WIDTH-1:0]   in_a;
    logic [LANES*DATA_WIDTH-1:0]   in_b;
    logic [LANES*DATA_WIDTH-1:0]   out_a;
    logic [LANES*DATA_WIDTH-1:0]   out_b;
    logic                          out_valid;
    logic                          out_last;
    logic                          acc_valid;
    logic                          acc_ready;
    logic [ACC_WIDTH-1:0]          acc_out;
    logic                          acc_sat;

    modport master (
        output in_valid, in_last, in_a, in_b, acc_ready,
        input  in_ready, out_a, out_b, out_valid, out_last, acc_valid, acc_out, acc_sat
    );

    modport slave (
        input  in_valid, in_last, in_a, in_b, acc_ready,
        output in_ready, out_a, out_b, out_valid, out_last, acc_valid, acc_out, acc_sat
    );
endinterface

// File: rtl/pe_mac_acc.sv
// Systolic PE: register operands, multiply/sum lanes, accumulate until last, hold result behind valid/ready.
// Optional clamping on accumulator overflow when PE_SATURATE_EN is defined.
module pe_mac_acc #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int LANES      = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    pe_mac_acc_if.slave   bus
);
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int SUM_WIDTH  = 2 * DATA_WIDTH + $clog2(LANES);
    localparam int BUS_WIDTH  = LANES * DATA_WIDTH;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} res_state_t;

    res_state_t                    state_reg, state_next;
    logic                          advance;
    logic                          load_result;
    logic [BUS_WIDTH-1:0]          a1_reg, b1_reg;
    logic                          v1_reg, last1_reg;
    logic signed [PROD_WIDTH-1:0]  prod [LANES];
    logic signed [SUM_WIDTH-1:0]   sum_next, sum2_reg;
    logic                          v2_reg, last2_reg;
    logic signed [ACC_WIDTH-1:0]   acc_reg, acc_next, acc_out_reg;

    // A pending result that nobody takes stalls every stage, including pass-through.
    assign advance      = enable && !(state_reg == FULL && !bus.acc_ready);
    assign load_result  = advance && v2_reg && last2_reg;
    assign bus.in_ready = advance;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign prod[gi] = $signed(a1_reg[gi*DATA_WIDTH +: DATA_WIDTH])
                            * $signed(b1_reg[gi*DATA_WIDTH +: DATA_WIDTH]);
        end
    endgenerate

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_next = sum_next + SUM_WIDTH'(prod[i]);
        end
    end

`ifdef PE_SATURATE_EN
    logic signed [ACC_WIDTH:0] wide_sum;
    logic                      clamp;
    logic                      sat_sticky_reg, acc_sat_reg;

    assign wide_sum = (ACC_WIDTH+1)'(acc_reg) + (ACC_WIDTH+1)'(sum2_reg);

    // Overflow shows as disagreement between the extra sign bit and the result MSB.
    always_comb begin
        acc_next = wide_sum[ACC_WIDTH-1:0];
        clamp    = 1'b0;
        if (wide_sum[ACC_WIDTH] != wide_sum[ACC_WIDTH-1]) begin
            clamp    = 1'b1;
            acc_next = wide_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                           : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_sticky_reg <= 1'b0;
            acc_sat_reg    <= 1'b0;
        end else if (advance && v2_reg) begin
            if (last2_reg) begin
                acc_sat_reg    <= sat_sticky_reg | clamp;
                sat_sticky_reg <= 1'b0;
            end else begin
                sat_sticky_reg <= sat_sticky_reg | clamp;
            end
        end
    end

    assign bus.acc_sat = acc_sat_reg;
`else
    assign acc_next    = acc_reg + ACC_WIDTH'(sum2_reg);
    assign bus.acc_sat = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY:   if (load_result) state_next = FULL;
            FULL:    if (bus.acc_ready && !load_result) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= EMPTY;
            a1_reg      <= '0;
            b1_reg      <= '0;
            v1_reg      <= 1'b0;
            last1_reg   <= 1'b0;
            sum2_reg    <= '0;
            v2_reg      <= 1'b0;
            last2_reg   <= 1'b0;
            acc_reg     <= '0;
            acc_out_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (advance) begin
                a1_reg    <= bus.in_a;
                b1_reg    <= bus.in_b;
                last1_reg <= bus.in_last;
                v1_reg    <= bus.in_valid;
                sum2_reg  <= sum_next;
                v2_reg    <= v1_reg;
                last2_reg <= last1_reg;
                if (v2_reg) begin
                    if (last2_reg) begin
                        acc_out_reg <= acc_next;
                        acc_reg     <= '0;
                    end else begin
                        acc_reg     <= acc_next;
                    end
                end
            end
        end
    end

    assign bus.out_a     = a1_reg;
    assign bus.out_b     = b1_reg;
    assign bus.out_valid = v1_reg;
    assign bus.out_last  = last1_reg;
    assign bus.acc_valid = (state_reg == FULL);
    assign bus.acc_out   = acc_out_reg;
endmodule
